// File: rtl/atp_change_dispenser.sv
// Change dispenser: pays an excess amount back as Rs 1000/500/100/50 notes,
// largest first, over a req/ack handshake, with per-denomination stock.

module atp_stock_cell #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_data,
    input  logic             dec,
    output logic [CNT_W-1:0] count
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (wr)
            count <= wr_data;
        else if (dec && count != '0)
            count <= count - 1'b1;
    end
endmodule

module atp_change_dispenser #(
    parameter int TIMEOUT_CYCLES = 39062,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [9:0]       amount,
    input  logic             load,
    input  logic [1:0]       load_sel,
    input  logic [CNT_W-1:0] load_count,
    input  logic             mech_ack,
    output logic             note_req,
    output logic [3:0]       note_sel,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic             timeout,
    output logic [9:0]       remaining,
    output logic [9:0]       dispensed,
    output logic [CNT_W-1:0] stock_1000,
    output logic [CNT_W-1:0] stock_500,
    output logic [CNT_W-1:0] stock_100,
    output logic [CNT_W-1:0] stock_50
);
    localparam int NUM_DEN = 4;
    localparam int TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_SELECT, S_REQ, S_DONE, S_FAIL
    } state_t;

    state_t state_q, state_d;

    logic [9:0]                    remaining_q, dispensed_q;
    logic [1:0]                    sel_idx_q;
    logic [TO_W-1:0]               tmr_q;
    logic                          timeout_q;
    logic [NUM_DEN-1:0][CNT_W-1:0] stock;
    logic [NUM_DEN-1:0]            stock_wr, stock_dec;

    logic       pick_found;
    logic [1:0] pick_idx;
    logic [9:0] sel_val, rem_after;
    logic       ack_hit, to_hit;

    // Index 0..3 = Rs 1000/500/100/50, in Rs 50 units.
    function automatic logic [9:0] unit_val(input logic [1:0] idx);
        case (idx)
            2'd0:    unit_val = 10'd20;
            2'd1:    unit_val = 10'd10;
            2'd2:    unit_val = 10'd2;
            default: unit_val = 10'd1;
        endcase
    endfunction

    // Scan smallest to largest so the largest qualifying note is the final winner.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = 2'd0;
        for (int i = NUM_DEN - 1; i >= 0; i--) begin
            if (unit_val(2'(i)) <= remaining_q && stock[i] != '0) begin
                pick_found = 1'b1;
                pick_idx   = 2'(i);
            end
        end
    end

    assign sel_val   = unit_val(sel_idx_q);
    assign rem_after = remaining_q - sel_val;
    assign ack_hit   = (state_q == S_REQ) && mech_ack;
    assign to_hit    = (state_q == S_REQ) && !mech_ack && (tmr_q == TO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_CHECK;
            S_CHECK:  state_d = (remaining_q == '0) ? S_DONE : S_SELECT;
            S_SELECT: state_d = pick_found ? S_REQ : S_FAIL;
            S_REQ: begin
                if (mech_ack)
                    state_d = (rem_after == '0) ? S_DONE : S_SELECT;
                else if (tmr_q == TO_LAST)
                    state_d = S_FAIL;
            end
            S_DONE:   state_d = S_IDLE;
            S_FAIL:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            remaining_q <= '0;
            dispensed_q <= '0;
            sel_idx_q   <= '0;
            tmr_q       <= '0;
            timeout_q   <= 1'b0;
        end else begin
            timeout_q <= to_hit;
            case (state_q)
                S_IDLE: begin
                    tmr_q <= '0;
                    if (start) begin
                        remaining_q <= amount;
                        dispensed_q <= '0;
                    end
                end
                S_SELECT: begin
                    tmr_q <= '0;
                    if (pick_found) sel_idx_q <= pick_idx;
                end
                S_REQ: begin
                    if (mech_ack) begin
                        remaining_q <= rem_after;
                        dispensed_q <= dispensed_q + sel_val;
                        tmr_q       <= '0;
                    end else if (to_hit) begin
                        tmr_q <= '0;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                default: tmr_q <= '0;
            endcase
        end
    end

    // Loads only land in IDLE and lose to a simultaneous start.
    genvar g;
    generate
        for (g = 0; g < NUM_DEN; g++) begin : g_stock
            assign stock_wr[g]  = (state_q == S_IDLE) && load && !start && (load_sel == 2'(g));
            assign stock_dec[g] = ack_hit && (sel_idx_q == 2'(g));
            atp_stock_cell #(.CNT_W(CNT_W)) u_cell (
                .clk     (clk),
                .reset   (reset),
                .wr      (stock_wr[g]),
                .wr_data (load_count),
                .dec     (stock_dec[g]),
                .count   (stock[g])
            );
        end
    endgenerate

    assign note_req   = (state_q == S_REQ);
    assign note_sel   = note_req ? (4'b1000 >> sel_idx_q) : 4'b0000;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign fail       = (state_q == S_FAIL);
    assign timeout    = timeout_q;
    assign remaining  = remaining_q;
    assign dispensed  = dispensed_q;
    assign stock_1000 = stock[0];
    assign stock_500  = stock[1];
    assign stock_100  = stock[2];
    assign stock_50   = stock[3];
endmodule

// File: tb/tb_atp_change_dispenser.sv
// Bench for atp_change_dispenser: table vectors, hand-written corner sequences
// and random transactions checked against a greedy-payout reference model.

module tb_atp_change_dispenser;
    localparam int T     = 16;
    localparam int CNT_W = 8;
    localparam int NEVER = 255;
    localparam int VAL [4] = '{20, 10, 2, 1};

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [9:0]       amount = '0;
    logic             load = 1'b0;
    logic [1:0]       load_sel = '0;
    logic [CNT_W-1:0] load_count = '0;
    logic             mech_ack = 1'b0;
    logic             note_req, busy, done, fail, timeout;
    logic [3:0]       note_sel;
    logic [9:0]       remaining, dispensed;
    logic [CNT_W-1:0] stock_1000, stock_500, stock_100, stock_50;

    atp_change_dispenser #(.TIMEOUT_CYCLES(T), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .amount(amount),
        .load(load), .load_sel(load_sel), .load_count(load_count),
        .mech_ack(mech_ack), .note_req(note_req), .note_sel(note_sel),
        .busy(busy), .done(done), .fail(fail), .timeout(timeout),
        .remaining(remaining), .dispensed(dispensed),
        .stock_1000(stock_1000), .stock_500(stock_500),
        .stock_100(stock_100), .stock_50(stock_50)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int dut_stock(input int i);
        case (i)
            0:       return int'(stock_1000);
            1:       return int'(stock_500);
            2:       return int'(stock_100);
            default: return int'(stock_50);
        endcase
    endfunction

    function automatic int sel_to_idx(input logic [3:0] s);
        case (s)
            4'b1000: return 0;
            4'b0100: return 1;
            4'b0010: return 2;
            4'b0001: return 3;
            default: return -1;
        endcase
    endfunction

    // Reference model state
    int m_stock [4];
    int m_notes [$];
    bit m_ok, m_to;
    int m_disp, m_rem, m_end;

    task automatic model_txn(input int amt, input int dly);
        int rem, t, pick;
        m_notes.delete();
        rem = amt; m_disp = 0; m_ok = 0; m_to = 0; t = 2;
        if (amt == 0) begin
            m_ok = 1; m_end = 2;
        end else begin
            forever begin
                pick = -1;
                for (int i = 3; i >= 0; i--)
                    if (VAL[i] <= rem && m_stock[i] > 0) pick = i;
                if (pick < 0) begin m_end = t + 1; break; end
                m_notes.push_back(pick);
                if (dly >= T) begin m_to = 1; m_end = t + 1 + T; break; end
                m_stock[pick]--;
                rem    -= VAL[pick];
                m_disp += VAL[pick];
                if (rem == 0) begin m_ok = 1; m_end = t + 2 + dly; break; end
                t = t + 2 + dly;
            end
        end
        m_rem = rem;
    endtask

    // Observed transaction results
    int   r_notes [$];
    int   r_done, r_fail, r_to, r_first_req, r_end, r_last_run;
    bit   r_sel_bad, r_to_alone, r_fin;

    task automatic do_load(input int sel, input int cnt);
        @(negedge clk);
        load = 1'b1; load_sel = 2'(sel); load_count = CNT_W'(cnt);
        @(negedge clk);
        load = 1'b0;
        m_stock[sel] = cnt;
        chk("load_stock", dut_stock(sel), cnt);
    endtask

    task automatic run_txn(input int amt, input int dly, input bit ld_with_start);
        int k;
        logic [3:0] cur;
        r_notes.delete();
        r_done = 0; r_fail = 0; r_to = 0; r_first_req = -1; r_end = -1;
        r_last_run = 0; r_sel_bad = 0; r_to_alone = 0; r_fin = 0; k = 0; cur = '0;
        @(negedge clk);
        start = 1'b1; amount = 10'(amt);
        if (ld_with_start) begin load = 1'b1; load_sel = 2'd3; load_count = 8'd77; end
        @(negedge clk);
        start = 1'b0; load = 1'b0;
        for (int c = 1; c < 4000 && !r_fin; c++) begin
            mech_ack = 1'b0;
            if (timeout && !fail) r_to_alone = 1;
            if (done || fail) begin
                r_done = int'(done); r_fail = int'(fail); r_to = int'(timeout);
                r_end = c; r_fin = 1;
            end else if (note_req) begin
                if (r_first_req < 0) r_first_req = c;
                if (!$onehot(note_sel)) r_sel_bad = 1;
                if (k == 0) r_notes.push_back(sel_to_idx(note_sel));
                else if (note_sel != cur) r_sel_bad = 1;
                cur = note_sel;
                if (k == dly) mech_ack = 1'b1;
                k++;
                r_last_run = k;
            end else begin
                if (note_sel != 4'b0000) r_sel_bad = 1;
                k = 0;
            end
            if (!r_fin) @(negedge clk);
        end
        mech_ack = 1'b0;
        if (!r_fin) chk("txn_bound", 0, 1);
    endtask

    task automatic check_txn(input string tag, input int amt);
        chk({tag, "_done"},    r_done, int'(m_ok));
        chk({tag, "_fail"},    r_fail, int'(!m_ok));
        chk({tag, "_timeout"}, r_to, int'(m_to));
        chk({tag, "_to_alone"}, int'(r_to_alone), 0);
        chk({tag, "_disp"},    int'(dispensed), m_disp);
        chk({tag, "_rem"},     int'(remaining), m_rem);
        chk({tag, "_sum"},     int'(dispensed) + int'(remaining), amt);
        chk({tag, "_end_cyc"}, r_end, m_end);
        chk({tag, "_sel_ok"},  int'(r_sel_bad), 0);
        chk({tag, "_nnotes"},  r_notes.size(), m_notes.size());
        for (int i = 0; i < r_notes.size() && i < m_notes.size(); i++)
            chk({tag, "_note"}, r_notes[i], m_notes[i]);
        chk({tag, "_first_req"}, r_first_req, (m_notes.size() > 0) ? 3 : -1);
        if (m_to) chk({tag, "_req_len"}, r_last_run, T);
        for (int i = 0; i < 4; i++) chk({tag, "_stock"}, dut_stock(i), m_stock[i]);
    endtask

    typedef struct {
        logic [3:0][7:0] ld;
        int              amt;
        int              dly;
        bit              ld_start;
        bit              e_done;
        bit              e_to;
        int              e_disp;
        int              e_rem;
        logic [3:0][7:0] e_st;
    } vec_t;

    function automatic vec_t mk(input logic [3:0][7:0] ld, input int amt, input int dly,
                                input bit ls, input bit ed, input bit et, input int edp,
                                input int er, input logic [3:0][7:0] es);
        vec_t v;
        v.ld = ld; v.amt = amt; v.dly = dly; v.ld_start = ls; v.e_done = ed;
        v.e_to = et; v.e_disp = edp; v.e_rem = er; v.e_st = es;
        return v;
    endfunction

    vec_t tv [6];

    initial begin
        // ld/e_st packed as {50,100,500,1000}: index 0 is Rs 1000
        tv[0] = mk({8'd5, 8'd5, 8'd5, 8'd5}, 32, 3, 0, 1, 0, 32, 0, {8'd5, 8'd4, 8'd4, 8'd4});
        tv[1] = mk({8'd0, 8'd3, 8'd1, 8'd0}, 40, 1, 0, 0, 0, 16, 24, {8'd0, 8'd0, 8'd0, 8'd0});
        tv[2] = mk({8'd2, 8'd0, 8'd0, 8'd0}, 1, NEVER, 0, 0, 1, 0, 1, {8'd2, 8'd0, 8'd0, 8'd0});
        tv[3] = mk({8'd2, 8'd2, 8'd2, 8'd2}, 0, 0, 1, 1, 0, 0, 0, {8'd2, 8'd2, 8'd2, 8'd2});
        tv[4] = mk({8'd4, 8'd0, 8'd0, 8'd3}, 21, 0, 0, 1, 0, 21, 0, {8'd3, 8'd0, 8'd0, 8'd2});
        tv[5] = mk({8'd255, 8'd255, 8'd255, 8'd255}, 1023, 0, 0, 1, 0, 1023, 0,
                   {8'd254, 8'd254, 8'd255, 8'd204});
        for (int i = 0; i < 4; i++) m_stock[i] = 0;

        // Reset state
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_note_req", int'(note_req), 0);
        chk("rst_flags", int'({done, fail, timeout}), 0);
        chk("rst_rem", int'(remaining), 0);
        chk("rst_disp", int'(dispensed), 0);
        for (int i = 0; i < 4; i++) chk("rst_stock", dut_stock(i), 0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", int'(busy), 0);

        // Table vectors
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 4; i++) do_load(i, int'(tv[v].ld[i]));
            model_txn(tv[v].amt, tv[v].dly);
            run_txn(tv[v].amt, tv[v].dly, tv[v].ld_start);
            check_txn("vec", tv[v].amt);
            chk("vec_tbl_done", r_done, int'(tv[v].e_done));
            chk("vec_tbl_timeout", r_to, int'(tv[v].e_to));
            chk("vec_tbl_disp", int'(dispensed), tv[v].e_disp);
            chk("vec_tbl_rem", int'(remaining), tv[v].e_rem);
            for (int i = 0; i < 4; i++) chk("vec_tbl_stock", dut_stock(i), int'(tv[v].e_st[i]));
        end

        // Async reset in the middle of a request
        do_load(3, 2);
        @(negedge clk); start = 1'b1; amount = 10'd1;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 20 && !note_req; c++) @(negedge clk);
        chk("mid_req_reached", int'(note_req), 1);
        #2 reset = 1'b0;
        #1;
        chk("arst_note_req", int'(note_req), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_note_sel", int'(note_sel), 0);
        for (int i = 0; i < 4; i++) chk("arst_stock", dut_stock(i), 0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) m_stock[i] = 0;
        @(negedge clk);
        chk("arst_idle", int'(busy), 0);
        chk("arst_rem", int'(remaining), 0);

        // start/load during REQ, ack held into SELECT, ack on final timeout cycle
        do_load(0, 1);
        do_load(1, 1);
        @(negedge clk); start = 1'b1; amount = 10'd30;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("h_req1", int'(note_req), 1);
        chk("h_sel1", int'(note_sel), 8);
        load = 1'b1; load_sel = 2'd0; load_count = 8'd99; start = 1'b1; amount = 10'd5;
        @(negedge clk);
        load = 1'b0; start = 1'b0; mech_ack = 1'b1;
        @(negedge clk);
        chk("h_select_gap", int'(note_req), 0);
        @(negedge clk);
        mech_ack = 1'b0;
        chk("h_req2", int'(note_req), 1);
        chk("h_sel2", int'(note_sel), 4);
        chk("h_stock500_mid", int'(stock_500), 1);
        repeat (T - 1) @(negedge clk);
        chk("h_req_last", int'(note_req), 1);
        mech_ack = 1'b1;
        @(negedge clk);
        mech_ack = 1'b0;
        chk("h_done", int'(done), 1);
        chk("h_fail", int'(fail), 0);
        chk("h_timeout", int'(timeout), 0);
        chk("h_stock1000", int'(stock_1000), 0);
        chk("h_stock500", int'(stock_500), 0);
        chk("h_disp", int'(dispensed), 30);
        chk("h_rem", int'(remaining), 0);
        m_stock[0] = 0; m_stock[1] = 0;
        @(negedge clk);
        chk("h_idle", int'(busy), 0);

        // Random transactions
        for (int n = 0; n < 40; n++) begin
            int amt, dly;
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 1) == 1) do_load(i, int'($urandom_range(0, 4)));
            amt = int'($urandom_range(0, 150));
            dly = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, T - 1));
            model_txn(amt, dly);
            run_txn(amt, dly, 1'b0);
            check_txn("rnd", amt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/atp_change_dispenser.md
# atp_change_dispenser

Cash-out counterpart of the ATP bill-payment cash acceptor. When the payment controller finds excess payment, it hands the excess to this block, which pays it back as notes. The block dispenses Rs 1000 / 500 / 100 / 50 notes one at a time, largest denomination first, through a request/acknowledge handshake with the note mechanism. It tracks per-denomination stock and reports done, fail, or timeout to the controller.

## Interface
- TIMEOUT_CYCLES, 39062, cycles allowed in REQ without mech_ack before abort
- CNT_W, 8, width of each stock counter
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin dispensing `amount`; sampled only in IDLE
- amount  in  10  excess to return, in Rs 50 units (1000=20, 500=10, 100=2, 50=1)
- load  in  1  stock write strobe; honoured only in IDLE
- load_sel  in  2  0=Rs1000, 1=Rs500, 2=Rs100, 3=Rs50
- load_count  in  CNT_W  new stock count; replaces, does not add
- mech_ack  in  1  mechanism has ejected the requested note; ignored outside REQ
- note_req  out  1  note request, high exactly while in REQ
- note_sel  out  4  one-hot {1000,500,100,50}; valid and stable while note_req=1, else 0
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse (DONE state)
- fail  out  1  one-cycle pulse (FAIL state)
- timeout  out  1  one-cycle pulse, coincident with fail on timeout abort
- remaining  out  10  units still owed
- dispensed  out  10  units paid out in current/last transaction
- stock_1000, stock_500, stock_100, stock_50  out  CNT_W each  current stock counts

## Operation
- States: IDLE, CHECK, SELECT, REQ, DONE, FAIL.
- IDLE
  - start=1: latch remaining<=amount, dispensed<=0, go to CHECK.
  - load=1 with start=0: write the selected stock.
  - load and start both high: start wins and load is dropped.
- CHECK
  - remaining==0: go to DONE.
  - Otherwise: go to SELECT.
- SELECT
  - Choose the largest denomination whose value is <= remaining and whose stock is > 0, then register note_sel and go to REQ.
  - If no denomination qualifies, go to FAIL with timeout=0. This is a greedy rule; no backtracking.
- REQ
  - Timeout counter increments each cycle.
  - mech_ack=1: decrement the selected stock, remaining -= value, dispensed += value, clear the counter. Go to SELECT if the new remaining is not 0, else DONE.
  - Counter reaches TIMEOUT_CYCLES-1 with no ack: go to FAIL and assert timeout. Stock, remaining and dispensed are unchanged for that note.
  - mech_ack wins if it arrives on the final timeout cycle.
- DONE / FAIL: assert the pulse for one cycle, then return to IDLE.
- remaining and dispensed hold their values in IDLE until the next start.
- Arithmetic
  - Unit values are 20/10/2/1.
  - remaining never underflows, because of the <= check.
  - dispensed + remaining == amount at all times in a transaction.
  - Stock never underflows, because of the >0 check.
- start and load outside IDLE are ignored.

## Timing
- Reset (asynchronous, reset=0)
  - State goes to IDLE.
  - All outputs go to 0, including all stock counters and the timeout counter.
  - Applies immediately, including mid-REQ (note_req drops without waiting for a clock).
- All outputs are registered or pure Moore decodes of state.
- start at edge t: CHECK in t+1, SELECT in t+2, note_req=1 from t+3.
- Each note takes 2 cycles minimum (SELECT + one REQ cycle with ack). note_req falls in the cycle after ack is sampled.
- amount=0: done pulses in cycle t+2, IDLE at t+3.
- Last note acked at edge e: DONE during e+1, IDLE at e+2.
- Timeout: FAIL occupies cycle TIMEOUT_CYCLES after REQ entry.
- load at edge t: the stock output is updated from t+1.

## Test plan
- Load 5 of each; start, amount=32 (Rs1600), ack each request after 3 cycles -> note_sel sequence 1000, 500, 100; done pulse; dispensed=32, remaining=0; stock 4, 4, 4, 5.
- Load 1000=0, 500=1, 100=3, 50=0; amount=40 -> notes 500, 100, 100, 100, then fail (timeout=0); dispensed=16, remaining=24; stock 0, 0, 0, 0.
- Load 50=2; amount=1; never ack -> note_req high for TIMEOUT_CYCLES cycles, then fail and timeout pulse together; stock_50 stays 2, remaining=1.
- amount=0 -> done pulse exactly 2 cycles after start, with no note_req. Also: load asserted in the same cycle as start is ignored.
- Mid-REQ, pulse reset low -> note_req, busy and all stock outputs read 0 before the next clock edge. After release, in IDLE.
- During REQ, assert load and start, and pulse mech_ack while in SELECT -> stock unchanged by load, no restart, no extra decrement. Ack given on the final timeout cycle is counted: no timeout pulse.
